fd_fetch_buffer: RTL and testbench
==================================

Name: fd_fetch_buffer

Overview:
- Small FIFO between the fetch stage (PC register plus instruction memory read) and the decode stage of the 5-stage MIPS pipeline.
- Decouples the PC enable from decode stalls: the PC advances whenever this buffer has room, and decode drains entries at its own pace.
- Flags instruction-fetch address errors (AdEL) per entry.
- Supports a one-cycle flush for control-flow redirects.

Parameters:
- DEPTH, 2: number of entries. Must be a power of 2, at least 2.
- IM_BASE, 32'h0000_3000: lowest legal fetch address.
- IM_SIZE, 32'h0000_4000: size in bytes of the legal fetch window.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; 0 clears the buffer on the next rising clk edge.
- pc_F  in  32  fetch address from the PC register.
- instr_F  in  32  instruction read at pc_F.
- valid_F  in  1  fetch offers {pc_F, instr_F} this cycle.
- ready_F  out  1  buffer can accept; drives the PC register's en.
- flush  in  1  discard all entries (redirect).
- stall_D  in  1  decode cannot consume this cycle.
- pc_D  out  32  PC of the head entry.
- instr_D  out  32  instruction of the head entry.
- exc_D  out  1  head entry has a fetch address error.
- valid_D  out  1  head entry is valid.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Pointers and count go to 0.
  - valid_D=0, pc_D=0, instr_D=0, exc_D=0, ready_F=1.
  - Reset dominates flush, push and pop.
- Storage: circular array of DEPTH entries {pc, instr, exc}. Read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- ready_F = (count != DEPTH). It depends only on registered state; there is no combinational path from stall_D.
- Push: valid_F && ready_F && !flush. The entry is written at the write pointer, and the write pointer increments.
- Pop: valid_D && !stall_D && !flush. The read pointer increments.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together (only possible when count < DEPTH): unchanged.
  - Push attempted while full: ignored. Fetch must hold pc_F, since the PC register is not enabled.
- Latency: when the buffer is empty, an entry pushed at edge N is presented at the outputs after edge N, i.e. valid_D=1 in cycle N+1. There is no combinational bypass from the F inputs to the D outputs.
- Outputs:
  - valid_D = (count != 0).
  - When valid_D=1, pc_D/instr_D/exc_D show the head entry.
  - When valid_D=0, all three are forced to 0, so decode sees a nop bubble.
- Exception capture at push:
  - exc = (pc_F[1:0] != 0) || pc_F < IM_BASE || pc_F >= IM_BASE+IM_SIZE.
  - If exc=1, the stored instr is 32'h0 and the stored pc is pc_F unchanged, for the EPC.
  - The range comparison is unsigned 32-bit. IM_BASE+IM_SIZE is computed in 33 bits so it cannot wrap.
- Flush (flush==1 at an edge, reset inactive):
  - Pointers and count go to 0.
  - A same-cycle push and pop are both discarded.
  - Next cycle: valid_D=0, ready_F=1.
- Stall with count==0: no effect.
- Stall while full: state frozen; ready_F=0 holds the PC.

Decomposition:
- const.v: IM_BASE/IM_SIZE defaults as macros shared with the instruction memory, and the AdEL ExcCode (4) for later use by the CP0 logic.
- No sub-module. Storage, pointers and the address check all live in this module.
- The entry width (65 bits) is a localparam.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with valid_F=1 -> valid_D=0, pc_D=0, instr_D=0, count=0, ready_F=1.
2. Single push, no stall: pc_F=32'h3000, instr_F=32'h3C01_1234 for 1 cycle -> next cycle valid_D=1, pc_D=32'h3000, instr_D=32'h3C01_1234. Popped the following edge, leaving count=0.
3. Fill and drain (stall_D=1):
   - Push 32'h3000 then 32'h3004 -> count=2, ready_F=0.
   - A third offer of 32'h3008 is not accepted.
   - Release the stall -> pc_D is 32'h3000, then 32'h3004, then 32'h3008, in that order, with no loss or duplication.
4. Simultaneous push and pop at count=1 -> count stays 1, head advances to the newly pushed PC one cycle later.
5. Flush:
   - With count=2, assert flush together with valid_F=1 (pc_F=32'h300C) -> next cycle count=0, valid_D=0, and 32'h300C is not stored.
   - The following push of 32'h4000 is accepted normally.
6. Exceptions and mid-operation reset:
   - Push pc_F=32'h3002 -> exc_D=1, instr_D=0, pc_D=32'h3002.
   - Push pc_F=32'h7000 -> exc_D=1.
   - Push pc_F=32'h6FFC -> exc_D=0.
   - Drive reset=0 with count=2 -> next cycle everything is cleared as in scenario 1.

Source files
------------

// File: rtl/fd_fetch_buffer_pkg.sv
// rtl/fd_fetch_buffer_pkg.sv - shared fetch-window constants, entry layout and AdEL check
package fd_fetch_buffer_pkg;

  // Instruction-memory window defaults, shared with the instruction memory.
  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_SIZE_DEFAULT = 32'h0000_4000;

  // ExcCode for an address error on load/fetch, reserved for CP0.
  localparam logic [4:0]  EXC_CODE_ADEL   = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fb_entry_t;

  // The window limit is formed in 33 bits so base+size can never wrap.
  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    logic [32:0] limit;
    limit = {1'b0, base} + {1'b0, size};
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fd_fetch_buffer.sv
// rtl/fd_fetch_buffer.sv - fetch-to-decode FIFO with per-entry AdEL flag and redirect flush
module fd_fetch_buffer
  import fd_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH   = 2,
  parameter logic [31:0] IM_BASE = IM_BASE_DEFAULT,
  parameter logic [31:0] IM_SIZE = IM_SIZE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc_F,
  input  logic [31:0]                instr_F,
  input  logic                       valid_F,
  output logic                       ready_F,
  input  logic                       flush,
  input  logic                       stall_D,
  output logic [31:0]                pc_D,
  output logic [31:0]                instr_D,
  output logic                       exc_D,
  output logic                       valid_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int ENTRY_W = 65;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  fb_entry_t new_entry;
  fb_entry_t head;
  logic      push;
  logic      pop;

  assign ready_F = (count_q != FULL_CNT);
  assign valid_D = (count_q != '0);
  assign count   = count_q;

  assign push = valid_F && ready_F && !flush;
  assign pop  = valid_D && !stall_D && !flush;

  // A faulting fetch keeps its PC for the EPC but carries a nop instruction.
  always_comb begin
    new_entry     = '0;
    new_entry.pc  = pc_F;
    new_entry.exc = fetch_addr_err(pc_F, IM_BASE, IM_SIZE);
    new_entry.instr = new_entry.exc ? 32'h0 : instr_F;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Empty buffer presents a zeroed bubble rather than stale storage.
  assign head    = mem_q[rd_ptr_q];
  assign pc_D    = valid_D ? head.pc    : 32'h0;
  assign instr_D = valid_D ? head.instr : 32'h0;
  assign exc_D   = valid_D ? head.exc   : 1'b0;

endmodule

// File: tb/tb_fd_fetch_buffer.sv
// tb/tb_fd_fetch_buffer.sv - directed self-checking bench for fd_fetch_buffer
module tb_fd_fetch_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_F;
  logic [31:0] instr_F;
  logic        valid_F;
  logic        ready_F;
  logic        flush;
  logic        stall_D;
  logic [31:0] pc_D;
  logic [31:0] instr_D;
  logic        exc_D;
  logic        valid_D;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  fd_fetch_buffer #(.DEPTH(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .valid_F (valid_F),
    .ready_F (ready_F),
    .flush   (flush),
    .stall_D (stall_D),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .exc_D   (exc_D),
    .valid_D (valid_D),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".valid_D"}, 32'(valid_D), 32'd0);
    chk({tag, ".pc_D"},    pc_D,         32'h0);
    chk({tag, ".instr_D"}, instr_D,      32'h0);
    chk({tag, ".exc_D"},   32'(exc_D),   32'd0);
    chk({tag, ".count"},   32'(count),   32'd0);
    chk({tag, ".ready_F"}, 32'(ready_F), 32'd1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; stall_D = 1'b0;
    valid_F = 1'b1; pc_F = 32'h3000; instr_F = 32'h1111_1111;
    step(); step();
    chk_cleared("reset");

    // single push, popped on the following edge
    reset = 1'b1; pc_F = 32'h3000; instr_F = 32'h3C01_1234;
    step();
    valid_F = 1'b0;
    chk("push1.valid_D", 32'(valid_D), 32'd1);
    chk("push1.pc_D",    pc_D,         32'h3000);
    chk("push1.instr_D", instr_D,      32'h3C01_1234);
    chk("push1.count",   32'(count),   32'd1);
    step();
    chk("pop1.count",   32'(count),   32'd0);
    chk("pop1.valid_D", 32'(valid_D), 32'd0);

    // fill under stall, third offer refused, then ordered drain
    stall_D = 1'b1; valid_F = 1'b1; pc_F = 32'h3000; instr_F = 32'hA000_0000;
    step();
    pc_F = 32'h3004; instr_F = 32'hB000_0000;
    step();
    chk("fill.count",   32'(count),   32'd2);
    chk("fill.ready_F", 32'(ready_F), 32'd0);
    pc_F = 32'h3008; instr_F = 32'hC000_0000;
    step();
    chk("full.count", 32'(count), 32'd2);
    chk("full.pc_D",  pc_D,       32'h3000);
    stall_D = 1'b0;
    step();
    chk("drain1.pc_D",    pc_D,         32'h3004);
    chk("drain1.count",   32'(count),   32'd1);
    chk("drain1.ready_F", 32'(ready_F), 32'd1);
    step();
    valid_F = 1'b0;
    chk("drain2.pc_D",    pc_D,       32'h3008);
    chk("drain2.instr_D", instr_D,    32'hC000_0000);
    chk("drain2.count",   32'(count), 32'd1);

    // simultaneous push and pop at count 1
    valid_F = 1'b1; pc_F = 32'h300C; instr_F = 32'hD000_0000;
    step();
    chk("pushpop.count", 32'(count), 32'd1);
    chk("pushpop.pc_D",  pc_D,       32'h300C);

    // flush at count 2 discards the offered entry
    stall_D = 1'b1; pc_F = 32'h3010; instr_F = 32'hE000_0000;
    step();
    chk("preflush.count", 32'(count), 32'd2);
    flush = 1'b1; pc_F = 32'h300C;
    step();
    flush = 1'b0; valid_F = 1'b0;
    chk("flush.count",   32'(count),   32'd0);
    chk("flush.valid_D", 32'(valid_D), 32'd0);
    chk("flush.ready_F", 32'(ready_F), 32'd1);
    step();
    chk("flush.nostore", 32'(count), 32'd0);
    stall_D = 1'b0; valid_F = 1'b1; pc_F = 32'h4000; instr_F = 32'h2222_2222;
    step();
    valid_F = 1'b0;
    chk("postflush.pc_D",  pc_D,       32'h4000);
    chk("postflush.exc_D", 32'(exc_D), 32'd0);
    chk("postflush.count", 32'(count), 32'd1);
    step();
    chk("postflush.drain", 32'(count), 32'd0);

    // address-error capture; each entry is popped as the next one arrives
    valid_F = 1'b1; pc_F = 32'h3002; instr_F = 32'h1234_5678;
    step();
    chk("misalign.exc_D",   32'(exc_D), 32'd1);
    chk("misalign.instr_D", instr_D,    32'h0);
    chk("misalign.pc_D",    pc_D,       32'h3002);
    pc_F = 32'h7000; instr_F = 32'h3333_3333;
    step();
    chk("above.exc_D", 32'(exc_D), 32'd1);
    chk("above.pc_D",  pc_D,       32'h7000);
    pc_F = 32'h6FFC; instr_F = 32'h4444_4444;
    step();
    chk("top.exc_D",   32'(exc_D), 32'd0);
    chk("top.instr_D", instr_D,    32'h4444_4444);
    pc_F = 32'h2FFC; instr_F = 32'h5555_5555;
    step();
    chk("below.exc_D",   32'(exc_D), 32'd1);
    chk("below.instr_D", instr_D,    32'h0);

    // mid-operation reset with the buffer full and a push offered
    stall_D = 1'b1; pc_F = 32'h3010; instr_F = 32'h6666_6666;
    step();
    chk("prereset.count", 32'(count), 32'd2);
    reset = 1'b0;
    step();
    chk_cleared("midreset");
    reset = 1'b1; valid_F = 1'b0; stall_D = 1'b0;
    step();
    chk("afterreset.count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
